// File: rtl/prim_dom_and_seq.sv
// prim_dom_and_seq
// -----------------------------------------------------------------------------
// Upstream sequencer for a non-pipelined 2-share DOM AND multiplier.
// It takes one masked operand pair per transaction and holds it in operand
// flops. It also buffers one word of fresh entropy. It then issues exactly one
// z_valid pulse per operation and captures the multiplier's output shares
// into an output register with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Valid is never withdrawn by this block before it is
// accepted. Ready does not depend on valid in the same cycle.
//
// Optional feature macro: PRIM_DOM_SEQ_PRD_MIX_EN
//   When defined, dom_prd_i is captured at the HOLD capture edge into prd_q,
//   and dom_z_o becomes the entropy buffer XOR prd_q.
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   clr_i                       synchronous flush (highest priority)
//   in_valid_i/in_ready_o       operand pair handshake
//   a0_i, a1_i, b0_i, b1_i      operand shares
//   ent_req_o/ent_ack_i/ent_i   entropy refill interface
//   dom_a0_o..dom_b1_o          multiplier operand shares
//   dom_z_o, dom_z_valid_o      multiplier randomness
//   dom_q0_i, dom_q1_i          multiplier output shares
//   dom_prd_i                   multiplier prd output (mix feature only)
//   out_valid_o/out_ready_i     result handshake
//   out_q0_o, out_q1_o          result shares
//   busy_o                      FSM is not IDLE
// -----------------------------------------------------------------------------
module prim_dom_and_seq #(
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  output logic          ent_req_o,
  input  logic          ent_ack_i,
  input  logic [DW-1:0] ent_i,
  output logic [DW-1:0] dom_a0_o,
  output logic [DW-1:0] dom_a1_o,
  output logic [DW-1:0] dom_b0_o,
  output logic [DW-1:0] dom_b1_o,
  output logic [DW-1:0] dom_z_o,
  output logic          dom_z_valid_o,
  input  logic [DW-1:0] dom_q0_i,
  input  logic [DW-1:0] dom_q1_i,
  input  logic [DW-1:0] dom_prd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_q0_o,
  output logic [DW-1:0] out_q1_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          in_fire;
  logic          z_fire;
  logic          capture;

  logic [DW-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [DW-1:0] ent_q;
  logic          ent_full_q;
  logic [DW-1:0] q0_q, q1_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    z_fire      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = ISSUE;
      end
      ISSUE: begin
        // Wait here until a fresh word is buffered, so that each word
        // backs exactly one z_valid pulse.
        if (ent_full_q) begin
          z_fire  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The multiplier's shares are settled in this cycle. They are
        // sampled at the edge that ends HOLD.
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      z_fire  = 1'b0;
      capture = 1'b0;
    end
  end

  assign in_fire       = in_ready_o && in_valid_i && !clr_i;
  assign dom_z_valid_o = z_fire;
  assign busy_o        = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Operand flops: change only on the input handshake. This keeps the
  // multiplier inputs stable from the z_valid cycle through the capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else if (clr_i) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else if (in_fire) begin
      a0_q <= a0_i;
      a1_q <= a1_i;
      b0_q <= b0_i;
      b1_q <= b1_i;
    end
  end

  assign dom_a0_o = a0_q;
  assign dom_a1_o = a1_q;
  assign dom_b0_o = b0_q;
  assign dom_b1_o = b1_q;

  // ---------------------------------------------------------------------------
  // Entropy buffer. It refills independently of the FSM. A used word is wiped
  // together with the full flag so that it cannot be reused.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q      <= '0;
      ent_full_q <= 1'b0;
    end else if (clr_i) begin
      ent_q      <= '0;
      ent_full_q <= 1'b0;
    end else if (z_fire) begin
      ent_q      <= '0;
      ent_full_q <= 1'b0;
    end else if (ent_ack_i && !ent_full_q) begin
      ent_q      <= ent_i;
      ent_full_q <= 1'b1;
    end
  end

  assign ent_req_o = !ent_full_q;

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (clr_i) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (capture) begin
      q0_q <= dom_q0_i;
      q1_q <= dom_q1_i;
    end
  end

  assign out_q0_o = q0_q;
  assign out_q1_o = q1_q;

`ifdef PRIM_DOM_SEQ_PRD_MIX_EN
  // The previous operation's prd value is folded into the next z. This
  // stretches the external entropy across back-to-back operations.
  logic [DW-1:0] prd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prd_q <= '0;
    end else if (clr_i) begin
      prd_q <= '0;
    end else if (capture) begin
      prd_q <= dom_prd_i;
    end
  end

  assign dom_z_o = ent_q ^ prd_q;
`else
  logic unused_prd;
  assign unused_prd = ^dom_prd_i;
  assign dom_z_o    = ent_q;
`endif

endmodule

// File: tb/tb_prim_dom_and_seq.sv
// Testbench for prim_dom_and_seq (DW = 8).
// A behavioural stand-in for the non-pipelined 2-share DOM AND multiplier
// feeds dom_q0/dom_q1 and dom_prd. Results are scored against the unmasked
// product (a0^a1)&(b0^b1).
module tb_prim_dom_and_seq;
  localparam int DW = 8;
`ifdef PRIM_DOM_SEQ_PRD_MIX_EN
  localparam bit MIX = 1'b1;
`else
  localparam bit MIX = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a0, a1, b0, b1;
  logic          ent_req;
  logic          ent_ack;
  logic [DW-1:0] ent;
  logic [DW-1:0] dom_a0, dom_a1, dom_b0, dom_b1, dom_z;
  logic          dom_z_valid;
  logic [DW-1:0] dom_q0, dom_q1, dom_prd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_q0, out_q1;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] prd_prev;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  prim_dom_and_seq #(.DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a0_i(a0), .a1_i(a1), .b0_i(b0), .b1_i(b1),
    .ent_req_o(ent_req), .ent_ack_i(ent_ack), .ent_i(ent),
    .dom_a0_o(dom_a0), .dom_a1_o(dom_a1), .dom_b0_o(dom_b0), .dom_b1_o(dom_b1),
    .dom_z_o(dom_z), .dom_z_valid_o(dom_z_valid),
    .dom_q0_i(dom_q0), .dom_q1_i(dom_q1), .dom_prd_i(dom_prd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_q0_o(out_q0), .out_q1_o(out_q1), .busy_o(busy)
  );

  // Multiplier stand-in: the inner-domain terms are registered every cycle.
  // The cross-domain terms are reshared with z and registered only on
  // z_valid.
  logic [DW-1:0] inner0_q, inner1_q, cross0_q, cross1_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner0_q <= '0; inner1_q <= '0; cross0_q <= '0; cross1_q <= '0;
    end else begin
      inner0_q <= dom_a0 & dom_b0;
      inner1_q <= dom_a1 & dom_b1;
      if (dom_z_valid) begin
        cross0_q <= (dom_a0 & dom_b1) ^ dom_z;
        cross1_q <= (dom_a1 & dom_b0) ^ dom_z;
      end
    end
  end
  assign dom_q0  = inner0_q ^ cross0_q;
  assign dom_q1  = inner1_q ^ cross1_q;
  assign dom_prd = (dom_a0 & dom_b1) ^ (dom_a1 & dom_b0);

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a drive point: 1 time unit after posedge)
  // ---------------------------------------------------------------------------
  task automatic fill_ent(input logic [DW-1:0] v);
    ent_ack = 1'b1; ent = v;
    @(posedge clk); #1;
    ent_ack = 1'b0; ent = $urandom_range(0, 255);
  endtask

  // Runs one operation. ent_delay = 0 means the buffer is already full.
  // Otherwise ent_late is offered in the cycle numbered ent_delay after the
  // accept. bp is the number of extra DONE cycles with out_ready held low.
  task automatic run_op(input logic [DW-1:0] va0, va1, vb0, vb1,
                        input int ent_delay, input logic [DW-1:0] ent_late,
                        input int bp, input logic [DW-1:0] exp_z,
                        output logic [DW-1:0] xr);
    int z_cyc, z_cnt, out_cyc, exp_zc;
    logic stable, bp_ok;
    logic [DW-1:0] zval, q0, q1;
    z_cyc = -1; z_cnt = 0; out_cyc = -1; stable = 1'b1; bp_ok = 1'b1;
    zval = '0; q0 = '0; q1 = '0;
    exp_zc = (ent_delay > 0) ? ent_delay + 1 : 1;
    in_valid = 1'b1; a0 = va0; a1 = va1; b0 = vb0; b1 = vb1; out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_at_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a0 = $urandom_range(0, 255); a1 = $urandom_range(0, 255);
    b0 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
    exp_q.push_back((va0 ^ va1) & (vb0 ^ vb1));
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (ent_delay > 0 && cyc == ent_delay) begin
        ent_ack = 1'b1; ent = ent_late;
      end else begin
        ent_ack = 1'b0;
      end
      @(negedge clk);
      if (dom_z_valid) begin
        z_cnt++;
        if (z_cyc < 0) begin z_cyc = cyc; zval = dom_z; end
      end
      if ({dom_a0, dom_a1, dom_b0, dom_b1} !== {va0, va1, vb0, vb1}) stable = 1'b0;
      if (out_valid) begin
        out_cyc = cyc; q0 = out_q0; q1 = out_q1;
        break;
      end
      @(posedge clk); #1;
    end
    ent_ack = 1'b0;
    chk("out_valid_timeout", (out_cyc >= 0), 1);
    chk("z_valid_pulses", z_cnt, 1);
    chk("z_valid_cycle", z_cyc, exp_zc);
    chk("dom_z_value", zval, exp_z);
    chk("out_valid_cycle", out_cyc, exp_zc + 2);
    chk("operands_stable", stable, 1);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      // One word fills the idle buffer. A second word offered while full
      // must be dropped.
      if (k == 2) begin ent_ack = 1'b1; ent = 8'h3C; end
      else if (k == 4) begin ent_ack = 1'b1; ent = 8'hC3; end
      else ent_ack = 1'b0;
      @(negedge clk);
      if (!out_valid || in_ready || out_q0 !== q0 || out_q1 !== q1) bp_ok = 1'b0;
    end
    ent_ack = 1'b0;
    if (bp > 0) begin
      chk("backpressure_stable", bp_ok, 1);
      chk("ent_req_after_fill", ent_req, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    xr = q0 ^ q1;
    if (exp_q.size() > 0) chk("result_xor", xr, exp_q.pop_front());
    else chk("scoreboard_empty", 1, 0);
    prd_prev = (va0 & vb1) ^ (va1 & vb0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ent_req"}, ent_req, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_z_valid"}, dom_z_valid, 0);
    chk({tag, "_wide"}, {out_q0, out_q1, dom_a0, dom_a1, dom_b0, dom_b1, dom_z}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] a0, a1, b0, b1, ent, exp_x;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [DW-1:0] xr, ra0, ra1, rb0, rb1, rent;
    vecs[0] = '{8'h5A, 8'hAA, 8'h0F, 8'h33, 8'hA5, 8'h30};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h11, 8'hFF};
    vecs[2] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h22, 8'h00};
    vecs[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h3C, 8'h26};
    vecs[4] = '{8'h80, 8'h01, 8'hC3, 8'h3C, 8'h77, 8'h81};
    vecs[5] = '{8'hF0, 8'h0F, 8'hAA, 8'hA5, 8'h01, 8'h0F};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; ent_ack = 1'b0; ent = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; out_ready = 1'b0; prd_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: the buffer is prefilled, so the latency is the minimum.
    foreach (vecs[i]) begin
      fill_ent(vecs[i].ent);
      run_op(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, 0, '0, 0,
             vecs[i].ent ^ (MIX ? prd_prev : 8'h00), xr);
      chk($sformatf("table_xor_%0d", i), xr, vecs[i].exp_x);
    end

    // Entropy stall: the buffer is empty at accept and the word arrives in cycle 5.
    run_op(8'h5A, 8'hAA, 8'h0F, 8'h33, 5, 8'h96, 0,
           8'h96 ^ (MIX ? prd_prev : 8'h00), xr);
    chk("stall_xor", xr, 8'h30);

    // Backpressure: 10 stalled DONE cycles, then a fill followed by a dropped word.
    fill_ent(8'h4B);
    run_op(8'hC0, 8'h3F, 8'h81, 8'h18, 0, '0, 10,
           8'h4B ^ (MIX ? prd_prev : 8'h00), xr);
    // The next operation must consume 0x3C, not the dropped 0xC3.
    run_op(8'h01, 8'h02, 8'h03, 8'h04, 0, '0, 0,
           8'h3C ^ (MIX ? prd_prev : 8'h00), xr);

    // Flush during HOLD.
    fill_ent(8'h5A);
    in_valid = 1'b1; a0 = 8'h77; a1 = 8'h11; b0 = 8'h22; b1 = 8'h44;
    @(posedge clk); #1;          // cycle 1 (ISSUE)
    in_valid = 1'b0;
    @(posedge clk); #1;          // cycle 2 (HOLD)
    clr = 1'b1;
    @(negedge clk);
    chk("clr_hold_busy", busy, 1);
    chk("clr_z_valid", dom_z_valid, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk_reset_outputs("clr");
    prd_prev = '0;

    // Asynchronous reset while stalled in ISSUE (the buffer is empty).
    @(posedge clk); #1;
    in_valid = 1'b1; a0 = 8'h9C; a1 = 8'h21; b0 = 8'h48; b1 = 8'h8E;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("issue_stalled_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    prd_prev = '0;
    @(posedge clk); #1;

    // Recovery plus 100 random back-to-back operations with entropy ready.
    for (int n = 0; n < 100; n++) begin
      ra0 = $urandom_range(0, 255); ra1 = $urandom_range(0, 255);
      rb0 = $urandom_range(0, 255); rb1 = $urandom_range(0, 255);
      rent = $urandom_range(0, 255);
      fill_ent(rent);
      run_op(ra0, ra1, rb0, rb1, 0, '0, 0, rent ^ (MIX ? prd_prev : 8'h00), xr);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so that the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prim_dom_and_seq.md
# prim_dom_and_seq

Upstream sequencer for the 2-share DOM AND multiplier (`prim_dom_and_2share`, `Pipeline = 0`). It accepts one masked operand pair per valid/ready transaction and buffers one word of fresh entropy. It drives the multiplier with inputs held stable for the required two cycles, pulses `z_valid` exactly once per operation, and captures the resulting output shares into a valid/ready output register. It also serializes operations so the non-pipelined multiplier never mixes inner-domain terms of new data with reshared terms of old data.

## Interface
Parameters:
- `DW`, 64, share width; must equal the multiplier's `DW`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clr_i` in 1: synchronous abort/flush.
- `in_valid_i` in 1: operand pair offered.
- `in_ready_o` out 1: operand pair accepted when both `in_valid_i` and `in_ready_o` are high.
- `a0_i`, `a1_i`, `b0_i`, `b1_i` in DW each: operand shares.
- `ent_req_o` out 1: entropy buffer empty, requesting a word.
- `ent_ack_i` in 1: entropy word `ent_i` is valid this cycle.
- `ent_i` in DW: fresh random word.
- `dom_a0_o`, `dom_a1_o`, `dom_b0_o`, `dom_b1_o` out DW each: multiplier operand shares.
- `dom_z_o` out DW: multiplier randomness.
- `dom_z_valid_o` out 1: multiplier randomness valid.
- `dom_q0_i`, `dom_q1_i` in DW: multiplier output shares.
- `dom_prd_i` in DW: multiplier `prd_o`.
- `out_valid_o` out 1: result shares valid.
- `out_ready_i` in 1: result consumed.
- `out_q0_o`, `out_q1_o` out DW: result shares.
- `busy_o` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, HOLD, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready_o` = 1.
  - On handshake, register the four shares into operand flops and go to ISSUE.
- ISSUE:
  - If the entropy buffer is full: `dom_z_valid_o` = 1, `dom_z_o` = the buffer word, clear the buffer, go to HOLD.
  - Otherwise stay in ISSUE with `dom_z_valid_o` = 0 and operands unchanged.
- HOLD:
  - `dom_z_valid_o` = 0 and operands unchanged.
  - At the clock edge ending HOLD, sample `dom_q0_i`/`dom_q1_i` into the output registers and go to DONE.
- DONE:
  - `out_valid_o` = 1.
  - When `out_ready_i` = 1, go to IDLE. The output registers keep their values until the next capture.
- `dom_a*`/`dom_b*` are driven directly from the operand flops in every state. They change only on the IDLE handshake.
- `dom_z_o` is driven from the entropy buffer in all states. `dom_z_valid_o` is high only in ISSUE with the buffer full.
- Entropy buffer:
  - One DW-bit register plus a full flag; `ent_req_o` = !full.
  - `ent_ack_i` while `ent_req_o` = 1 loads `ent_i` and sets full.
  - `ent_ack_i` while full is ignored; the word is dropped and the buffer is unchanged.
  - The buffer is filled independently of the FSM, including in IDLE and DONE, so the next operation can issue without stalling.
  - Each entropy word is used for exactly one `dom_z_valid_o` pulse.
- `clr_i` takes priority over everything in the same cycle:
  - FSM goes to IDLE.
  - Operand flops, output registers and the entropy buffer (data and full flag) are zeroed.
  - `dom_z_valid_o` is forced to 0 in that cycle.

## Timing
- Reset values: `in_ready_o` = 1, `busy_o` = 0, `ent_req_o` = 1, `out_valid_o` = 0, `dom_z_valid_o` = 0. All DW-wide outputs reset to 0.
- Latency with the buffer already full:
  - Accept in cycle 0.
  - `dom_z_valid_o` in cycle 1.
  - Capture at the end of cycle 2.
  - `out_valid_o` from cycle 3.
- Each cycle of entropy stall in ISSUE adds one cycle of latency.
- Operands are stable from cycle 1 through the capture edge. This satisfies the multiplier's stability requirement: inputs stable in the `z_valid` cycle and the following cycle.
- Throughput: at most one operation per 4 cycles; the next accept can occur in the cycle after the `out_ready_i` handshake.
- Reset deasserting mid-operation is not special: asynchronous assertion returns everything to reset values immediately.

## Configuration
- `PRIM_DOM_SEQ_PRD_MIX_EN`, defined:
  - A DW-bit `prd_q` register (reset 0, cleared by `clr_i`) captures `dom_prd_i` at the HOLD capture edge.
  - `dom_z_o` = buffer XOR `prd_q`.
  - This stretches external entropy quality across back-to-back operations. Timing is unchanged.
- `PRIM_DOM_SEQ_PRD_MIX_EN` undefined:
  - `dom_z_o` = buffer; `dom_prd_i` is unused.
  - No `prd_q` flop exists.

## Test plan
All scenarios use DW=8 with the multiplier instance connected.
- Basic: prefill entropy with `ent_i`=0xA5; send a0=0x5A, a1=0xAA, b0=0x0F, b1=0x33 -> `dom_z_valid_o` in cycle 1 only; `out_valid_o` in cycle 3; `out_q0_o` ^ `out_q1_o` = 0x30.
- Entropy stall: buffer empty at accept, `ent_ack_i` arrives 5 cycles later -> FSM stays in ISSUE with operands stable; `dom_z_valid_o` rises in the cycle after the ack; result XOR is correct.
- Backpressure: hold `out_ready_i`=0 for 10 cycles -> `out_valid_o` and the result shares are stable; `in_ready_o`=0; an extra `ent_ack_i` while full leaves the buffer unchanged.
- Back-to-back: 100 random operand pairs with entropy always ready -> every result XOR equals (a0^a1)&(b0^b1); exactly one `dom_z_valid_o` pulse per operation; no operand change between the `z_valid` cycle and the capture.
- Flush/reset: assert `clr_i` in HOLD -> next cycle state is IDLE, `out_valid_o`=0, `ent_req_o`=1, `dom_z_valid_o`=0; repeat with `rst_ni` asserted in ISSUE -> all outputs are at reset values.
- With `PRIM_DOM_SEQ_PRD_MIX_EN` defined: second operation's `dom_z_o` = `ent_i` ^ the first operation's captured `dom_prd_i`; results remain correct.
